// File: rtl/q78_pkg.sv
// Shared types and constants for the quotient-to-pixel packer.
package q78_pkg;

    typedef logic [15:0] fx16_t;
    typedef logic [7:0]  pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pack_state_e;

    localparam logic [16:0] ROUND_HALF     = 17'h00080;
    localparam pixel_t      PIX_MAX        = 8'hFF;
    localparam int unsigned BYTES_PER_WORD = 4;

    // Byte enables for a word holding n low pixels (n==0 means none).
    function automatic logic [3:0] be_mask(input logic [1:0] n);
        case (n)
            2'd1:    be_mask = 4'b0001;
            2'd2:    be_mask = 4'b0011;
            2'd3:    be_mask = 4'b0111;
            default: be_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/q78_to_pixel.sv
// Round-half-up and clamp of one fixed-point quotient to an 8-bit pixel.
// Q78_SIGNED_EN selects signed Q7.8 input; default is unsigned Q8.8.
module q78_to_pixel
    import q78_pkg::*;
(
    input  fx16_t  in_data_i,
    output pixel_t pixel_o,
    output logic   clamp_o
);

    logic [16:0] sum;
    logic        unused_frac;

    assign unused_frac = ^sum[7:0];

`ifdef Q78_SIGNED_EN
    // Negative after rounding clamps to 0; largest positive result is 128.
    always_comb begin
        sum     = {in_data_i[15], in_data_i} + ROUND_HALF;
        pixel_o = sum[15:8];
        clamp_o = 1'b0;
        if (sum[16]) begin
            pixel_o = 8'h00;
            clamp_o = 1'b1;
        end
    end
`else
    // Only 0xFF80..0xFFFF round up to 256 and need clamping.
    always_comb begin
        sum     = {1'b0, in_data_i} + ROUND_HALF;
        pixel_o = sum[15:8];
        clamp_o = 1'b0;
        if (sum[16]) begin
            pixel_o = PIX_MAX;
            clamp_o = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/q78_pixel_packer.sv
// Packs four converted pixels into little-endian 32-bit words for the data
// memory write port; flush emits partial words. Conversion mode: Q78_SIGNED_EN.
module q78_pixel_packer
    import q78_pkg::*;
#(
    parameter int unsigned PIX_PER_WORD = 4,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_data,
    output logic [3:0]        out_be,
    output logic              busy,
    output logic              sat_flag
);

    if (PIX_PER_WORD != 4) begin : g_bad_pix_per_word
        $error("q78_pixel_packer: PIX_PER_WORD must be 4");
    end

    pack_state_e       state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       pack_q, pack_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic              valid_q, valid_d;
    logic              sat_q, sat_d;

    pixel_t            pix;
    logic              clamp;
    logic              accept;
    logic              can_load;
    logic [2:0]        lane_eff;
    logic [31:0]       pack_acc;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^base_addr[1:0];

    q78_to_pixel u_conv (
        .in_data_i (in_data),
        .pixel_o   (pix),
        .clamp_o   (clamp)
    );

    // Word register may take a new word if empty or being drained this cycle.
    assign can_load = !valid_q || out_ready;
    assign in_ready = (state_q == RUN) && !(lane_q == 2'd3 && valid_q && !out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        pack_d     = pack_q;
        addr_cnt_d = addr_cnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        be_d       = be_q;
        valid_d    = valid_q;
        sat_d      = sat_q;

        pack_acc = pack_q;
        if (accept) begin
            pack_acc[{lane_q, 3'b000} +: 8] = pix;
        end
        lane_eff = accept ? ({1'b0, lane_q} + 3'd1) : {1'b0, lane_q};

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    addr_cnt_d = {base_addr[ADDR_W-1:2], 2'b00};
                    lane_d     = 2'd0;
                    pack_d     = 32'd0;
                    sat_d      = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    sat_d  = sat_q | clamp;
                    pack_d = pack_acc;
                    lane_d = lane_q + 2'd1;
                    if (lane_eff == 3'd4) begin
                        word_d     = pack_acc;
                        be_d       = 4'b1111;
                        addr_d     = addr_cnt_q;
                        addr_cnt_d = addr_cnt_q + ADDR_W'(BYTES_PER_WORD);
                        valid_d    = 1'b1;
                        pack_d     = 32'd0;
                    end
                end
                if (flush) begin
                    state_d = DRAIN;
                    // A partial word that cannot load now stays in pack for DRAIN.
                    if (lane_eff != 3'd0 && lane_eff != 3'd4 && can_load) begin
                        word_d     = pack_acc;
                        be_d       = be_mask(lane_eff[1:0]);
                        addr_d     = addr_cnt_q;
                        addr_cnt_d = addr_cnt_q + ADDR_W'(BYTES_PER_WORD);
                        valid_d    = 1'b1;
                        pack_d     = 32'd0;
                        lane_d     = 2'd0;
                    end
                end
            end
            DRAIN: begin
                if (lane_q != 2'd0) begin
                    if (can_load) begin
                        word_d     = pack_q;
                        be_d       = be_mask(lane_q);
                        addr_d     = addr_cnt_q;
                        addr_cnt_d = addr_cnt_q + ADDR_W'(BYTES_PER_WORD);
                        valid_d    = 1'b1;
                        pack_d     = 32'd0;
                        lane_d     = 2'd0;
                    end
                end else if (can_load) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_q     <= 2'd0;
            pack_q     <= 32'd0;
            addr_cnt_q <= '0;
            word_q     <= 32'd0;
            addr_q     <= '0;
            be_q       <= 4'd0;
            valid_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            addr_cnt_q <= addr_cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            valid_q    <= valid_d;
            sat_q      <= sat_d;
        end
    end

    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_data  = word_q;
    assign out_be    = be_q;
    assign busy      = (state_q != IDLE);
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_q78_pixel_packer.sv
// Directed self-checking bench for q78_pixel_packer (either Q78_SIGNED_EN build).
module tb_q78_pixel_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        busy;
    logic        sat_flag;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    q78_pixel_packer #(.PIX_PER_WORD(4), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_be    (out_be),
        .busy      (busy),
        .sat_flag  (sat_flag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] data,
                              input logic [31:0] addr, input logic [3:0] be);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"},  out_data, data);
        check({tag, ".addr"},  out_addr, addr);
        check({tag, ".be"},    32'(out_be), 32'(be));
    endtask

    task automatic do_start(input logic [31:0] base);
        start = 1'b1; base_addr = base;
        tick();
        start = 1'b0;
    endtask

    logic [15:0] vec8 [8];
    logic [15:0] vec_bp [8];
    logic [15:0] sat_in;
    logic [31:0] sat_pix;

    initial begin
        vec8[0] = 16'h0100; vec8[1] = 16'h0280; vec8[2] = 16'h0A7F; vec8[3] = 16'h7F00;
        vec8[4] = 16'h0000; vec8[5] = 16'h007F; vec8[6] = 16'h0080; vec8[7] = 16'h3456;
        vec_bp[0] = 16'h0500; vec_bp[1] = 16'h0600; vec_bp[2] = 16'h0700; vec_bp[3] = 16'h0800;
        vec_bp[4] = 16'h0900; vec_bp[5] = 16'h0A00; vec_bp[6] = 16'h0B00; vec_bp[7] = 16'h0C00;
`ifdef Q78_SIGNED_EN
        sat_in = 16'hFF00; sat_pix = 32'h0000_0000;
`else
        sat_in = 16'hFFFF; sat_pix = 32'h0000_00FF;
`endif

        rst = 1'b1; start = 1'b0; base_addr = 32'd0; flush = 1'b0;
        in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data", out_data, 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.sat", 32'(sat_flag), 32'd0);

        // Misaligned base: low two bits are dropped.
        do_start(32'h0000_0102);
        check("run.busy", 32'(busy), 32'd1);

        // Eight back-to-back pixels, no stalls.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = vec8[i];
            #1;
            check($sformatf("b2b.in_ready%0d", i), 32'(in_ready), 32'd1);
            tick();
            if (i == 3) begin
                check_word("w0", 32'h7F0A_0301, 32'h100, 4'hF);
                check("w0.sat", 32'(sat_flag), 32'd0);
            end
            if (i == 7) check_word("w1", 32'h3401_0000, 32'h104, 4'hF);
        end
        in_valid = 1'b0;
        tick();
        check("w1.drained", 32'(out_valid), 32'd0);

        // Backpressure: second full word must wait on the first.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = vec_bp[i];
            tick();
        end
        in_data = vec_bp[7];
        #1;
        check("bp.in_ready_low", 32'(in_ready), 32'd0);
        tick();
        check_word("bp.hold1", 32'h0807_0605, 32'h108, 4'hF);
        tick();
        check_word("bp.hold2", 32'h0807_0605, 32'h108, 4'hF);
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_high", 32'(in_ready), 32'd1);
        tick();
        check_word("bp.w3", 32'h0C0B_0A09, 32'h10C, 4'hF);
        in_valid = 1'b0;
        tick();
        check("bp.drained", 32'(out_valid), 32'd0);

        // Partial word via flush.
        in_valid = 1'b1; in_data = 16'h0100; tick();
        in_data = 16'h0200; tick();
        in_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0;
        check_word("fl", 32'h0000_0201, 32'h110, 4'b0011);
        check("fl.busy", 32'(busy), 32'd1);
        tick();
        check("fl.idle_valid", 32'(out_valid), 32'd0);
        check("fl.idle_busy", 32'(busy), 32'd0);

        // Clamp with accept and flush in the same cycle; sat is sticky until start.
        do_start(32'h0000_0200);
        in_valid = 1'b1; in_data = sat_in; flush = 1'b1; tick();
        in_valid = 1'b0; flush = 1'b0;
        check_word("sat", sat_pix, 32'h200, 4'b0001);
        check("sat.flag", 32'(sat_flag), 32'd1);
        tick();
        check("sat.idle_busy", 32'(busy), 32'd0);
        check("sat.sticky", 32'(sat_flag), 32'd1);
        do_start(32'h0000_0300);
        check("sat.cleared", 32'(sat_flag), 32'd0);

        // Reset with full word register and partial pack pending.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = vec8[i];
            tick();
        end
        in_valid = 1'b0;
        check_word("mr.pend", 32'h7F0A_0301, 32'h300, 4'hF);
        rst = 1'b1; tick(); rst = 1'b0;
        #1;
        check("mr.out_valid", 32'(out_valid), 32'd0);
        check("mr.out_data", out_data, 32'd0);
        check("mr.out_addr", out_addr, 32'd0);
        check("mr.out_be", 32'(out_be), 32'd0);
        check("mr.busy", 32'(busy), 32'd0);
        check("mr.in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check("mr.no_word", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
